// File: rtl/tl_instruction_fetch.sv
// tl_instruction_fetch: PC, instruction memory and IF/ID register with halt detection
module tl_instruction_fetch #(
   parameter int              LEN        = 32,
   parameter int              RAM_DEPTH  = 256,
   parameter int              NB_ADDRESS = $clog2(RAM_DEPTH),
   parameter logic [LEN-1:0]  HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic [LEN-1:0]        i_pc_target,
   input  logic                  i_load_we,
   input  logic [NB_ADDRESS-1:0] i_load_addr,
   input  logic [LEN-1:0]        i_load_data,
   output logic [LEN-1:0]        o_instruccion,
   output logic [LEN-1:0]        o_adder_pc,
   output logic [LEN-1:0]        o_pc,
   output logic                  o_halt
);

   typedef enum logic {RUN, HALT} state_t;

   state_t         state;
   logic [LEN-1:0] pc;
   logic [LEN-1:0] mem [RAM_DEPTH];
   logic [LEN-1:0] word;
   logic [LEN-1:0] pc_next;

   assign word    = mem[pc[NB_ADDRESS+1:2]];
   assign pc_next = pc + LEN'(4);
   assign o_pc    = pc;
   assign o_halt  = (state == HALT);

   // program-load port, independent of reset, enable and FSM
   always_ff @(posedge i_clk) begin
      if (i_load_we) mem[i_load_addr] <= i_load_data;
   end

   // PC, FSM and IF/ID update: reset > enable > flush > stall > halt > normal
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         pc            <= '0;
         o_instruccion <= '0;
         o_adder_pc    <= '0;
         state         <= RUN;
      end else if (i_enable) begin
         if (i_flush) begin
            pc            <= i_pc_target & ~LEN'(3);
            o_instruccion <= '0;
            o_adder_pc    <= '0;
            state         <= RUN;
         end else if (!i_stall) begin
            if (state == HALT) begin
               o_instruccion <= '0;
               o_adder_pc    <= '0;
            end else if (word == HALT_WORD) begin
               o_instruccion <= HALT_WORD;
               o_adder_pc    <= pc_next;
               state         <= HALT;
            end else begin
               o_instruccion <= word;
               o_adder_pc    <= pc_next;
               pc            <= pc_next;
            end
         end
      end
   end

endmodule

// File: doc/tl_instruction_fetch.md
# tl_instruction_fetch

Instruction-fetch stage of the MIPS pipeline: holds the program counter, the instruction memory and the IF/ID pipeline register. It feeds the decode stage with the fetched instruction and its PC+4. It consumes the decode stage's stall flag and the branch/jump redirect (flush plus target), and detects the HALT word so the pipeline can drain.

## Interface
Parameters:
- LEN, 32, data/PC width
- RAM_DEPTH, 256, instruction memory depth in words
- NB_ADDRESS, $clog2(RAM_DEPTH), word-index width
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_enable  in  1  pipeline advance enable (debug step); 0 freezes PC, FSM and IF/ID
- i_stall  in  1  hazard stall from decode (o_flag_stall)
- i_flush  in  1  taken branch/jump; redirect PC and squash IF/ID
- i_pc_target  in  LEN  redirect byte address; bits [1:0] ignored
- i_load_we  in  1  program-load write strobe
- i_load_addr  in  NB_ADDRESS  program-load word index
- i_load_data  in  LEN  program-load word
- o_instruccion  out  LEN  IF/ID instruction to decode
- o_adder_pc  out  LEN  IF/ID PC+4 of o_instruccion
- o_pc  out  LEN  current PC (fetch address)
- o_halt  out  1  1 while FSM is in HALT

## Operation
- Memory: RAM_DEPTH x LEN array, combinational read at index pc[NB_ADDRESS+1:2]. PC bits above NB_ADDRESS+1 alias. Not cleared by reset.
- Load port: when i_load_we=1, mem[i_load_addr] <= i_load_data on the edge. This applies regardless of i_enable, i_rst or FSM state. A fetch of the same word in the same cycle reads the old contents.
- FSM states:
  - RUN: reset state.
  - HALT: entered from RUN on a normal-advance edge with mem[pc]==HALT_WORD. Left only by reset, or by i_flush (back to RUN).
- Per edge, priority order: reset > i_enable=0 > flush > stall > HALT > normal.
  - Reset: pc=0, o_instruccion=0, o_adder_pc=0, o_halt=0, state=RUN.
  - i_enable=0: all of pc, FSM and IF/ID hold.
  - Flush (RUN or HALT): pc <= {i_pc_target[LEN-1:2],2'b00}; o_instruccion <= 0 (NOP); o_adder_pc <= 0; state <= RUN. Flush beats stall and beats halt detection in the same cycle.
  - Stall: pc and IF/ID hold; FSM holds.
  - HALT state, no flush: pc holds; o_instruccion <= 0 and o_adder_pc <= 0 every enabled edge, so the pipeline drains with NOPs.
  - Normal, word != HALT_WORD: o_instruccion <= mem[pc]; o_adder_pc <= pc+4; pc <= pc+4.
  - Normal, word == HALT_WORD: o_instruccion <= HALT_WORD; o_adder_pc <= pc+4; pc holds; state <= HALT.
- Arithmetic: pc+4 is modulo 2^LEN (0xFFFFFFFC wraps to 0).
- o_pc = pc register. o_halt = (state==HALT).

## Timing
- Fetch latency: 1 edge from PC to IF/ID.
- Outputs are registered on the rising edge. Decode samples on the falling edge, so they are stable half a cycle before capture.
- Redirect: i_flush high before edge k gives a NOP on IF/ID after k. mem[target] with target+4 appears after k+1.
- Stall: IF/ID and pc unchanged for every edge where i_stall=1. On the first edge after release, fetch resumes at the held pc.
- o_halt rises after the edge that captures HALT_WORD into IF/ID. It falls after a flush edge or a reset edge.
- Reset takes effect mid-stall, mid-halt or mid-flush on the next edge, with the values listed under Operation.

## Test plan
- Load mem[0..3]=0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF; reset; run 3 edges. Required: IF/ID = (0x20010005, 4), (0x20020007, 8), (0x00221820, 12); pc=12.
- Stall high for 2 edges after the first fetch. Required: IF/ID stays (0x20010005, 4) and pc=4 for both edges; next edge gives (0x20020007, 8).
- i_flush=1, i_stall=1, target 0x0000000E at pc=8. Required: IF/ID=(0,0), pc=0x0C; next edge gives (mem[3], 0x10).
- Reach word 3 = HALT_WORD. Required: IF/ID=(0xFFFFFFFF, 16), o_halt=1, pc=12; the next 3 edges give IF/ID=(0,0) with pc=12.
- In HALT, flush to target 0. Required: o_halt=0 and IF/ID=(0,0) after that edge; next edge gives (0x20010005, 4).
- At pc=0, load 0xDEADBEEF into word 0 on the same edge. Required: IF/ID gets the old word 0x20010005; after a redirect to 0, fetch returns 0xDEADBEEF.
- i_enable=0 for 3 edges, with i_flush pulsed. Required: pc, IF/ID and o_halt unchanged throughout.
